wb_uart_tx: RTL and testbench

Wishbone B3 classic slave transmit UART for the J1 system, mapped by `wb_intercon` into one of the I/O windows (5000H, 6000H or 7000H) in place of a generic `wb_io` slave. The CPU writes bytes into a transmit FIFO. A baud-rate generator and shift FSM serialise them as 8N1 frames on `txd`. Status and divisor registers allow polled or interrupt-driven transmission.

---
 rtl/wb_uart_tx.sv | 199 +++++++++++++++++++
 tb/tb_wb_uart_tx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone B3 classic slave transmit UART (8N1).
//
// The CPU pushes bytes into a DEPTH-entry transmit FIFO; a baud counter and
// a four-state shift FSM serialise them on txd. The STATUS and DIVISOR
// registers support both polled and interrupt-driven transmission.
//
// Register map (wb_adr_i):
//   0 DATA    : write pushes wb_dat_i[7:0]; reads return 0
//   1 STATUS  : {level[15:8], 4'b0, ovf, full, empty, busy}; writing bit 3 clears ovf
//   2 DIVISOR : bit period is DIVISOR+1 clocks
//   3 reserved: reads 0, writes ignored
//
// Ports:
//   clk, reset_n            : clock, synchronous active-low reset
//   wb_cyc_i/stb_i/we_i     : Wishbone cycle, strobe, write enable
//   wb_adr_i[1:0]           : word register select
//   wb_dat_i[15:0]          : write data
//   wb_dat_o[15:0]          : registered read data, 0 when wb_ack_o is low
//   wb_ack_o                : registered acknowledge, one cycle per access
//   txd                     : serial output, idles high
//   irq_o                   : high while the FIFO is empty and the FSM is idle
module wb_uart_tx #(
   parameter int          DEPTH     = 16,
   parameter logic [15:0] DIV_RESET = 16'd867
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [1:0]  wb_adr_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        txd,
   output logic        irq_o
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0] level;
   logic [7:0]  level8;
   logic        empty, full;
   logic        ovf_reg;
   logic [15:0] div_reg;
   logic        ack_reg;
   logic [15:0] dat_reg;
   logic [15:0] rd_data;
   logic        accept, push_req, push, pop;

   state_t      state_reg, state_next;
   logic [15:0] baud_reg, baud_next;
   logic [2:0]  bit_cnt_reg, bit_cnt_next;
   logic [7:0]  shift_reg, shift_next;
   logic        txd_reg, txd_next;

   // The extra pointer bit distinguishes a full FIFO from an empty one.
   assign level  = wr_ptr_reg - rd_ptr_reg;
   assign level8 = 8'(level);
   assign empty  = (level == '0);
   assign full   = (level == (AW+1)'(DEPTH));

   assign accept   = wb_cyc_i & wb_stb_i & ~ack_reg;
   assign push_req = accept & wb_we_i & (wb_adr_i == 2'd0);
   // full is taken before the edge, so a pop in the same cycle never makes room.
   assign push     = push_req & ~full;

   // Read mux sees the state registered before the accepting edge.
   always_comb begin
      rd_data = '0;
      case (wb_adr_i)
         2'd1:    rd_data = {level8, 4'b0000, ovf_reg, full, empty, state_reg != IDLE};
         2'd2:    rd_data = div_reg;
         default: rd_data = '0;
      endcase
   end

   // FIFO storage: no reset so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg[AW-1:0]] <= wb_dat_i[7:0];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         ovf_reg    <= 1'b0;
         div_reg    <= DIV_RESET;
         ack_reg    <= 1'b0;
         dat_reg    <= '0;
      end else begin
         ack_reg <= accept;
         dat_reg <= (accept & ~wb_we_i) ? rd_data : '0;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         // A drop in the same cycle as a clear wins: the loss must stay visible.
         if (push_req & full)
            ovf_reg <= 1'b1;
         else if (accept & wb_we_i & (wb_adr_i == 2'd1) & wb_dat_i[3])
            ovf_reg <= 1'b0;
         if (accept & wb_we_i & (wb_adr_i == 2'd2))
            div_reg <= wb_dat_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         baud_reg    <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         txd_reg     <= 1'b1;
      end else begin
         state_reg   <= state_next;
         baud_reg    <= baud_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
         txd_reg     <= txd_next;
      end
   end

   // The baud counter is reloaded from div_reg only at bit boundaries, so a
   // divisor write never shortens or stretches the bit in progress.
   always_comb begin
      state_next   = state_reg;
      baud_next    = baud_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      pop          = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               pop          = 1'b1;
               shift_next   = mem[rd_ptr_reg[AW-1:0]];
               bit_cnt_next = 3'd7;
               baud_next    = div_reg;
               state_next   = START;
            end
         end
         START: begin
            if (baud_reg == '0) begin
               baud_next  = div_reg;
               state_next = DATA;
            end else begin
               baud_next = baud_reg - 1'b1;
            end
         end
         DATA: begin
            if (baud_reg == '0) begin
               baud_next = div_reg;
               if (bit_cnt_reg == '0) begin
                  state_next = STOP;
               end else begin
                  shift_next   = shift_reg >> 1;
                  bit_cnt_next = bit_cnt_reg - 1'b1;
               end
            end else begin
               baud_next = baud_reg - 1'b1;
            end
         end
         STOP: begin
            if (baud_reg == '0) begin
               // Chain straight into the next start bit when data is waiting.
               if (!empty) begin
                  pop          = 1'b1;
                  shift_next   = mem[rd_ptr_reg[AW-1:0]];
                  bit_cnt_next = 3'd7;
                  baud_next    = div_reg;
                  state_next   = START;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               baud_next = baud_reg - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      // txd is registered from the next state so the line is glitch-free.
      case (state_next)
         START:   txd_next = 1'b0;
         DATA:    txd_next = shift_next[0];
         default: txd_next = 1'b1;
      endcase
   end

   assign wb_ack_o = ack_reg;
   assign wb_dat_o = dat_reg;
   assign txd      = txd_reg;
   assign irq_o    = empty & (state_reg == IDLE);

endmodule

// File: tb/tb_wb_uart_tx.sv
// Testbench for wb_uart_tx: register vectors from a table, serial frames
// checked clock-by-clock against a queue of expected bytes and bit lengths.
module tb_wb_uart_tx;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        wb_cyc, wb_stb, wb_we;
   logic [1:0]  wb_adr;
   logic [15:0] wb_dat;
   logic [15:0] wb_dat_o;
   logic        wb_ack_o;
   logic        txd;
   logic        irq_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int n_frames = 0;
   int n_abort = 0;
   int last_start = 0;
   int prev_start = 0;

   typedef struct packed {
      logic [7:0]       data;
      logic [9:0][11:0] len;
   } exp_t;

   exp_t exp_q[$];

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  adr;
      logic [15:0] wdat;
      logic        chk;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[13];

   wb_uart_tx #(.DEPTH(16), .DIV_RESET(16'd867)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .wb_cyc_i (wb_cyc),
      .wb_stb_i (wb_stb),
      .wb_we_i  (wb_we),
      .wb_adr_i (wb_adr),
      .wb_dat_i (wb_dat),
      .wb_dat_o (wb_dat_o),
      .wb_ack_o (wb_ack_o),
      .txd      (txd),
      .irq_o    (irq_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic void push_exp(input logic [7:0] d, input int l_early,
                                    input int n_early, input int l_late);
      exp_t e;
      e.data = d;
      for (int b = 0; b < 10; b++)
         e.len[b] = 12'((b < n_early) ? l_early : l_late);
      exp_q.push_back(e);
   endfunction

   // One bus access; returns with time at #1 after the ack edge.
   task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [15:0] wdat,
                          output logic [15:0] rdat);
      bit got = 0;
      rdat   = '0;
      wb_cyc = 1'b1;
      wb_stb = 1'b1;
      wb_we  = we;
      wb_adr = adr;
      wb_dat = wdat;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk);
         #1;
         if (wb_ack_o) begin
            got     = 1;
            rdat    = wb_dat_o;
            acc_cyc = cyc;
         end
      end
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL bus_ack: no ack for adr=%0d, expected ack within 4 clocks", adr);
      end
      $display("bus %s adr=%0d wdat=%04h rdat=%04h cyc=%0d", we ? "wr" : "rd", adr, wdat, rdat, acc_cyc);
   endtask

   task automatic wait_frames(input int n, input int budget);
      for (int i = 0; i < budget && n_frames < n; i++) begin
         @(posedge clk);
         #1;
      end
      check("frame_count", n_frames, n);
   endtask

   // Serial monitor: on a start bit, pops the expected frame and compares
   // txd on every clock of all ten bits. A reset abandons the frame.
   initial begin : monitor
      exp_t       e;
      int         bad;
      bit         aborted;
      logic [7:0] rx;
      logic       exp_bit;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && txd === 1'b0) begin
            prev_start = last_start;
            last_start = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: start bit at cyc %0d, expected idle line", cyc);
               for (int i = 0; i < 20000 && txd !== 1'b1; i++) @(negedge clk);
            end else begin
               e       = exp_q.pop_front();
               bad     = 0;
               aborted = 0;
               rx      = '0;
               for (int b = 0; b < 10 && !aborted; b++) begin
                  for (int c = 0; c < int'(e.len[b]); c++) begin
                     if (!(b == 0 && c == 0)) @(negedge clk);
                     if (!reset_n) begin
                        aborted = 1;
                        break;
                     end
                     exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
                     if (txd !== exp_bit) bad++;
                     if (b >= 1 && b <= 8 && c == int'(e.len[b]) / 2) rx[b-1] = txd;
                  end
               end
               if (aborted) begin
                  n_abort++;
                  $display("frame abandoned by reset, expected byte %02h", e.data);
               end else begin
                  checks++;
                  if (bad != 0) begin
                     errors++;
                     $display("FAIL frame: got byte %02h with %0d wrong clocks, expected byte %02h", rx, bad, e.data);
                  end
                  n_frames++;
                  $display("frame rx=%02h start_cyc=%0d", rx, last_start);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [15:0] rd;
      int a, f0, fa;

      reset_n = 1'b0;
      wb_cyc  = 1'b0;
      wb_stb  = 1'b0;
      wb_we   = 1'b0;
      wb_adr  = '0;
      wb_dat  = '0;

      vecs[0]  = '{"rst_status",   1'b0, 2'd1, 16'h0000, 1'b1, 16'h0002};
      vecs[1]  = '{"rst_divisor",  1'b0, 2'd2, 16'h0000, 1'b1, 16'd867};
      vecs[2]  = '{"wr_div",       1'b1, 2'd2, 16'h1234, 1'b0, 16'h0000};
      vecs[3]  = '{"rd_div",       1'b0, 2'd2, 16'h0000, 1'b1, 16'h1234};
      vecs[4]  = '{"rd_rsvd",      1'b0, 2'd3, 16'h0000, 1'b1, 16'h0000};
      vecs[5]  = '{"wr_rsvd",      1'b1, 2'd3, 16'hFFFF, 1'b0, 16'h0000};
      vecs[6]  = '{"rd_rsvd2",     1'b0, 2'd3, 16'h0000, 1'b1, 16'h0000};
      vecs[7]  = '{"div_kept",     1'b0, 2'd2, 16'h0000, 1'b1, 16'h1234};
      vecs[8]  = '{"rd_data",      1'b0, 2'd0, 16'h0000, 1'b1, 16'h0000};
      vecs[9]  = '{"wr_status",    1'b1, 2'd1, 16'hFFF7, 1'b0, 16'h0000};
      vecs[10] = '{"status_idle",  1'b0, 2'd1, 16'h0000, 1'b1, 16'h0002};
      vecs[11] = '{"wr_div3",      1'b1, 2'd2, 16'h0003, 1'b0, 16'h0000};
      vecs[12] = '{"rd_div3",      1'b0, 2'd2, 16'h0000, 1'b1, 16'h0003};

      // Reset held for two clocks.
      repeat (2) @(posedge clk);
      #1;
      check("rst_txd", txd, 1);
      check("rst_irq", irq_o, 1);
      check("rst_ack", wb_ack_o, 0);
      check("rst_dat", wb_dat_o, 0);
      reset_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].wdat, rd);
         if (vecs[i].chk) check(vecs[i].name, rd, vecs[i].exp);
      end

      // Single byte at DIVISOR=3.
      push_exp(8'hA5, 4, 10, 4);
      f0 = n_frames;
      wb_xfer(1'b1, 2'd0, 16'h00A5, rd);
      a = acc_cyc;
      check("irq_deassert", irq_o, 0);
      wait_frames(f0 + 1, 200);
      check("single_start", last_start, a + 1);
      check("single_irq", irq_o, 1);
      wb_xfer(1'b0, 2'd1, 16'h0000, rd);
      check("single_status", rd, 16'h0002);

      // Back-to-back frames.
      push_exp(8'h55, 4, 10, 4);
      push_exp(8'h0F, 4, 10, 4);
      f0 = n_frames;
      wb_xfer(1'b1, 2'd0, 16'h0055, rd);
      wb_xfer(1'b1, 2'd0, 16'h000F, rd);
      wb_xfer(1'b0, 2'd1, 16'h0000, rd);
      check("b2b_level1", rd, 16'h0101);
      wait_frames(f0 + 1, 200);
      repeat (2) @(posedge clk);
      #1;
      wb_xfer(1'b0, 2'd1, 16'h0000, rd);
      check("b2b_level0", rd, 16'h0003);
      wait_frames(f0 + 2, 200);
      check("b2b_contiguous", last_start - prev_start, 40);

      // Overflow at DIVISOR=867; switch to 3 inside the first start bit.
      wb_xfer(1'b1, 2'd2, 16'd867, rd);
      push_exp(8'h30, 868, 1, 4);
      for (int i = 1; i <= 16; i++) push_exp(8'(8'h30 + i), 4, 10, 4);
      f0 = n_frames;
      for (int i = 0; i < 18; i++) wb_xfer(1'b1, 2'd0, 16'(16'h0030 + i), rd);
      wb_xfer(1'b0, 2'd1, 16'h0000, rd);
      check("ovf_status", rd, 16'h100D);
      wb_xfer(1'b1, 2'd1, 16'h0008, rd);
      wb_xfer(1'b0, 2'd1, 16'h0000, rd);
      check("ovf_cleared", rd, 16'h1005);
      wb_xfer(1'b1, 2'd2, 16'h0003, rd);
      wait_frames(f0 + 17, 2500);
      repeat (60) @(posedge clk);
      #1;
      check("ovf_no_extra", n_frames, f0 + 17);
      check("ovf_queue_empty", exp_q.size(), 0);
      wb_xfer(1'b0, 2'd1, 16'h0000, rd);
      check("ovf_final_status", rd, 16'h0002);

      // Divisor change during frame bit 2 (start is bit 0).
      push_exp(8'h3C, 4, 3, 2);
      f0 = n_frames;
      wb_xfer(1'b1, 2'd0, 16'h003C, rd);
      a = acc_cyc;
      repeat (10) @(posedge clk);
      #1;
      wb_xfer(1'b1, 2'd2, 16'h0001, rd);
      check("mid_div_accept", acc_cyc, a + 11);
      wait_frames(f0 + 1, 200);
      check("mid_start", last_start, a + 1);
      wb_xfer(1'b1, 2'd2, 16'h0003, rd);

      // One-clock reset during the data bits.
      push_exp(8'h81, 4, 10, 4);
      f0 = n_frames;
      fa = n_abort;
      wb_xfer(1'b1, 2'd0, 16'h0081, rd);
      repeat (14) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("rstmid_txd", txd, 1);
      check("rstmid_irq", irq_o, 1);
      wb_xfer(1'b0, 2'd1, 16'h0000, rd);
      check("rstmid_status", rd, 16'h0002);
      wb_xfer(1'b0, 2'd2, 16'h0000, rd);
      check("rstmid_divisor", rd, 16'd867);
      repeat (100) @(posedge clk);
      #1;
      check("rstmid_abandoned", n_abort, fa + 1);
      check("rstmid_no_frame", n_frames, f0);
      check("rstmid_txd_idle", txd, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
